// File: rtl/dm_cache_rd.sv
// Read-only direct-mapped cache: valid/tag/data arrays, miss-refill FSM and
// saturating hit/miss counters between a word-addressed requester and memory.
module dm_cache_rd #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned INDEX_W  = 8,
  parameter int unsigned OFFSET_W = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_data,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rdata_vld,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINES      = 2 ** INDEX_W;
  localparam int unsigned LINE_WORDS = 2 ** OFFSET_W;
  localparam int unsigned DATA_AW    = INDEX_W + OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL_DATA,
    S_RESP_MISS
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic [WORD_W-1:0]   resp_data_q, resp_data_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic [WORD_W-1:0]   data_arr [LINES*LINE_WORDS];
  logic [TAG_W-1:0]    tag_arr  [LINES];

  logic [TAG_W-1:0]    cur_tag;
  logic [INDEX_W-1:0]  cur_idx;
  logic [OFFSET_W-1:0] cur_off;
  logic [DATA_AW-1:0]  rd_addr;
  logic [DATA_AW-1:0]  wr_addr;
  logic [WORD_W-1:0]   rd_word;
  logic                lookup_hit;
  logic                data_we;
  logic                tag_we;

  assign cur_tag    = addr_q[ADDR_W-1 -: TAG_W];
  assign cur_idx    = addr_q[OFFSET_W +: INDEX_W];
  assign cur_off    = addr_q[OFFSET_W-1:0];
  assign rd_addr    = {cur_idx, cur_off};
  assign wr_addr    = {cur_idx, cnt_q};
  assign rd_word    = data_arr[rd_addr];
  assign lookup_hit = valid_q[cur_idx] && (tag_arr[cur_idx] == cur_tag);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    valid_d         = valid_q;
    resp_valid_d    = 1'b0;
    resp_hit_d      = resp_hit_q;
    resp_data_d     = resp_data_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    data_we         = 1'b0;
    tag_we          = 1'b0;
    req_ready       = (state_q == S_IDLE) && !flush;

    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (req_valid) begin
          addr_d  = req_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_data_d  = rd_word;
          hit_cnt_d    = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 1'b1;
          state_d      = S_IDLE;
        end else begin
          // Dropping the valid bit now means an aborted refill can never hit.
          miss_cnt_d       = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;
          valid_d[cur_idx] = 1'b0;
          mem_req_valid_d  = 1'b1;
          mem_req_addr_d   = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          state_d          = S_REFILL_REQ;
        end
      end
      S_REFILL_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          cnt_d           = '0;
          state_d         = S_REFILL_DATA;
        end
      end
      S_REFILL_DATA: begin
        if (mem_rdata_vld) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            tag_we           = 1'b1;
            valid_d[cur_idx] = 1'b1;
            state_d          = S_RESP_MISS;
          end
        end
      end
      S_RESP_MISS: begin
        resp_valid_d = 1'b1;
        resp_hit_d   = 1'b0;
        resp_data_d  = rd_word;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      cnt_q           <= '0;
      valid_q         <= '0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_data_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      cnt_q           <= cnt_d;
      valid_q         <= valid_d;
      resp_valid_q    <= resp_valid_d;
      resp_hit_q      <= resp_hit_d;
      resp_data_q     <= resp_data_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
    end
  end

  // Storage arrays carry no reset; the valid bits alone decide what may hit.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_arr[wr_addr] <= mem_rdata;
    end
    if (tag_we) begin
      tag_arr[cur_idx] <= cur_tag;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_hit      = resp_hit_q;
  assign resp_data     = resp_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;

endmodule
